// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: FIFO pop, error clear and status/data readback.
// master = CPU peripheral logic, slave = uart_rx_fifo.
interface uart_rx_fifo_if;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rd_en, err_clr,
    input  rx_data, rx_empty, rx_full, frame_err, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rx_data, rx_empty, rx_full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO and sticky
// framing/overrun error flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 2604,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_rx,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntHalf  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   CountMax = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rxs_q;
  logic            push, pop, can_accept;
  logic            frame_set, overrun_set;
  logic            frame_err_q, overrun_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      last_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bidx_d  = '0;
          state_d = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d           = '0;
          shift_d[bidx_q] = rxs_q;
          bidx_d          = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rxs_q) begin
            if (can_accept) push = 1'b1;
            else            overrun_set = 1'b1;
            state_d = StIdle;
          end else begin
            frame_set = 1'b1;
            state_d   = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a stuck-low line cannot retrigger.
        cnt_d = '0;
        if (rxs_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop        = bus.rd_en && (count_q != '0);
  assign can_accept = (count_q != CountMax) || pop;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~bus.err_clr);
      overrun_q   <= overrun_set | (overrun_q & ~bus.err_clr);
    end
  end

  // When empty, keep showing the most recently popped byte.
  assign bus.rx_data   = (count_q == '0) ? last_q : mem_q[rd_ptr_q];
  assign bus.rx_empty  = (count_q == '0);
  assign bus.rx_full   = (count_q == CountMax);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule
